rf_write_arbiter: RTL
=====================

# rf_write_arbiter

Shares the register file's single synchronous write port between the in-order writeback stage (WB) and the out-of-order long-latency unit (LL, mul/div). It tracks LL destinations in flight in a per-register busy scoreboard so decode can stall on RAW/WAW hazards. Fixed priority goes to WB, with a bounded-wait starvation guard for LL. It sits between WB/LL and the register file's wr_en/wr_idx/wr_data inputs.

## Interface
- XLEN, 32: data width.
- NREG, 32: register count; index width is $clog2(NREG).
- MAX_WAIT, 4: consecutive cycles LL may be refused before it is forced; legal range 1..15.

- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- wb_valid / wb_ready  in / out  1  WB write handshake.
- wb_idx / wb_data  in  5 / XLEN  WB destination and value.
- ll_valid / ll_ready  in / out  1  LL write handshake.
- ll_idx / ll_data  in  5 / XLEN  LL destination and value.
- ll_issue_valid / ll_issue_ready  in / out  1  LL dispatch handshake; reserves a destination.
- ll_issue_idx  in  5  destination being reserved.
- rs1_idx, rs2_idx, rd_idx  in  5  decode-stage query indices.
- rs1_busy, rs2_busy, rd_busy  out  1  queried register has an LL result pending.
- rf_wr_en / rf_wr_idx / rf_wr_data  out  1 / 5 / XLEN  to the register file write port.

## Operation
- **Handshake.** A transfer occurs on a cycle with valid && ready. Requesters hold idx/data stable while valid && !ready.
- **x0 writes.** A request with idx == 0 is accepted immediately (ready = 1) and never drives rf_wr_en. It does not consume the port, so the other requester may be granted in the same cycle.
- **State machine** (two states):
  - NORMAL:
    - WB wins a conflict. ll_ready = ll_valid && !(wb_valid && wb_idx != 0).
    - wait_cnt increments on each cycle with ll_valid && !ll_ready and clears on an LL transfer or when ll_valid is low.
    - When wait_cnt == MAX_WAIT-1 and LL is refused again, go to FORCE_LL.
  - FORCE_LL:
    - LL is granted unconditionally. wb_ready = 0 unless wb_idx == 0.
    - On the LL transfer, return to NORMAL and clear wait_cnt.
    - If ll_valid drops, return to NORMAL.
- **Write port mux.** rf_wr_en = granted requester with nonzero idx. rf_wr_idx and rf_wr_data come from that requester. When nothing is granted, idx and data are 0.
- **Scoreboard** (busy[NREG-1:1]; busy[0] is constant 0):
  - ll_issue_ready = !busy[ll_issue_idx]. This blocks a second in-flight LL op to the same destination. ll_issue_ready is always 1 for idx 0, and a reservation of idx 0 is a no-op.
  - An issue transfer sets busy[ll_issue_idx].
  - An LL write transfer clears busy[ll_idx].
  - A set and a clear of the same index in the same cycle: set wins.
  - WB writes never touch busy. Decode must stall on rd_busy to avoid WAW.
- rs*_busy / rd_busy = busy[query idx], combinational from registered state.
- **Reset.** busy = 0, wait_cnt = 0, state = NORMAL. While rst_n is low, all ready outputs, rf_wr_en and all *_busy outputs are 0. Asserting reset mid-operation discards pending reservations and forced state.

## Timing
- Grant, ready and the rf_wr_* outputs are combinational from the current valids and state: zero-cycle arbitration. The write lands at the same posedge as the transfer.
- busy set/clear take effect at the posedge of the transfer. The *_busy outputs reflect it in the next cycle.
- The register file's read-side bypass covers the write cycle. rs*_busy therefore deasserts the cycle after LL writeback with no data gap.
- Worst-case LL wait: MAX_WAIT refused cycles, then a grant in the following cycle.
- WB stall in FORCE_LL: exactly one cycle per forced LL write.

## Structure
- **Package rf_arb_pkg:**
  - arb_state_e enum {NORMAL, FORCE_LL}.
  - REG_IDX_W = 5.
  - WAIT_CNT_W = 4.
- **Sub-module rf_scoreboard:** busy vector, set/clear with set-wins priority, and the three query ports.
- **Top level:** FSM, wait counter and write-port mux.

## Test plan
- **Reset:** hold rst_n = 0 with all valids high. Require ready/wr_en/busy all 0. Release: WB idx 3 data 0xA5 gives rf_wr_en = 1, idx 3, 0xA5 in the same cycle.
- **Conflict:** WB idx 5 and LL idx 6 valid together. Require the WB write first (ll_ready = 0); LL idx 6 is written the next cycle once wb_valid drops.
- **Starvation:** MAX_WAIT = 4, WB valid continuously to nonzero idx, LL idx 9 valid. Require LL refused for 4 cycles, then granted in cycle 5 with wb_ready = 0, and wb_ready = 1 in cycle 6.
- **x0:** WB idx 0 and LL idx 7 in the same cycle. Require both ready = 1 and rf_wr_idx = 7 with LL data.
- **Scoreboard:**
  - Issue idx 12: rs1_idx = 12 gives rs1_busy = 1 the next cycle.
  - A second issue to idx 12 sees ll_issue_ready = 0.
  - The LL write to 12 clears busy, with rs1_busy = 0 the following cycle.
- **Set-wins:** an LL write to 14 and a new issue to 14 in the same cycle. Require busy[14] = 1 afterwards. A mid-operation reset clears it to 0.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
// State encoding and index/counter widths.
package rf_arb_pkg;
  typedef enum logic {
    NORMAL,
    FORCE_LL
  } arb_state_e;

  localparam int REG_IDX_W  = 5;
  localparam int WAIT_CNT_W = 4;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for LL results in flight.
// Set and clear in one cycle on the same index: set wins.
module rf_scoreboard
  import rf_arb_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] iss_idx,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  input  logic [REG_IDX_W-1:0] rd_idx,
  output logic                 iss_busy,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 rd_busy
);
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    if (clr_en)
      busy_nxt[clr_idx] = 1'b0;
    if (set_en)
      busy_nxt[set_idx] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  assign iss_busy = busy[iss_idx];
  assign rs1_busy = busy[rs1_idx];
  assign rs2_busy = busy[rs2_idx];
  assign rd_busy  = busy[rd_idx];
endmodule

// File: rtl/rf_write_arbiter.sv
// Single RF write port shared by WB (priority) and LL.
// LL is forced through after MAX_WAIT refused cycles.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic [REG_IDX_W-1:0] wb_idx,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 ll_valid,
  output logic                 ll_ready,
  input  logic [REG_IDX_W-1:0] ll_idx,
  input  logic [XLEN-1:0]      ll_data,
  input  logic                 ll_issue_valid,
  output logic                 ll_issue_ready,
  input  logic [REG_IDX_W-1:0] ll_issue_idx,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  input  logic [REG_IDX_W-1:0] rd_idx,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 rd_busy,
  output logic                 rf_wr_en,
  output logic [REG_IDX_W-1:0] rf_wr_idx,
  output logic [XLEN-1:0]      rf_wr_data
);
  localparam logic [WAIT_CNT_W-1:0] CNT_LAST =
    WAIT_CNT_W'(MAX_WAIT - 1);

  arb_state_e state, state_nxt;
  logic [WAIT_CNT_W-1:0] wait_cnt, cnt_nxt;
  logic wb_rdy, ll_rdy, wb_nz, refused;
  logic wb_gnt, ll_gnt, ll_xfer;
  logic iss_busy, set_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= NORMAL;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = refused ? wait_cnt + 1'b1 : '0;
    unique case (state)
      NORMAL:
        if (refused && wait_cnt == CNT_LAST)
          state_nxt = FORCE_LL;
      FORCE_LL:
        if (!ll_valid || ll_xfer)
          state_nxt = NORMAL;
      default: state_nxt = NORMAL;
    endcase
  end

  always_comb begin
    wb_nz  = wb_valid && wb_idx != '0;
    wb_rdy = 1'b0;
    ll_rdy = 1'b0;
    unique case (state)
      NORMAL: begin
        wb_rdy = wb_valid;
        ll_rdy = ll_valid && (ll_idx == '0 || !wb_nz);
      end
      FORCE_LL: begin
        wb_rdy = wb_valid && wb_idx == '0;
        ll_rdy = ll_valid;
      end
      default: ;
    endcase
  end

  assign wb_ready = rst_n && wb_rdy;
  assign ll_ready = rst_n && ll_rdy;
  assign refused  = ll_valid && !ll_ready;
  assign ll_xfer  = ll_valid && ll_ready;
  assign wb_gnt   = wb_valid && wb_ready && wb_idx != '0;
  assign ll_gnt   = ll_xfer && ll_idx != '0;

  always_comb begin
    rf_wr_en   = 1'b0;
    rf_wr_idx  = '0;
    rf_wr_data = '0;
    unique case (1'b1)
      wb_gnt: begin
        rf_wr_en   = 1'b1;
        rf_wr_idx  = wb_idx;
        rf_wr_data = wb_data;
      end
      ll_gnt: begin
        rf_wr_en   = 1'b1;
        rf_wr_idx  = ll_idx;
        rf_wr_data = ll_data;
      end
      default: ;
    endcase
  end

  assign ll_issue_ready = rst_n && !iss_busy;
  assign set_en = ll_issue_valid && ll_issue_ready;

  rf_scoreboard #(.NREG(NREG)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (set_en),
    .set_idx  (ll_issue_idx),
    .clr_en   (ll_xfer),
    .clr_idx  (ll_idx),
    .iss_idx  (ll_issue_idx),
    .rs1_idx  (rs1_idx),
    .rs2_idx  (rs2_idx),
    .rd_idx   (rd_idx),
    .iss_busy (iss_busy),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );
endmodule
